// File: rtl/vga_timing.sv
// 640x480@60 VGA pixel-timing generator: pixel-rate divider, raster counters,
// and a registered, blank-masked colour/sync stage so colour and sync leave aligned.
module vga_timing #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rIn,
  input  logic [2:0]  gIn,
  input  logic [2:0]  bIn,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        pixTick,
  output logic        frameStart,
  output logic [2:0]  r,
  output logic [2:0]  g,
  output logic [2:0]  b,
  output logic        hs,
  output logic        vs
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             lineEnd;
  logic             frameEnd;
  logic             active;
  logic             hsNext;
  logic             vsNext;

  // Pixel-rate enable; with CLK_DIV == 1 div stays 0 and pixTick is constantly high.
  assign pixTick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || pixTick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_comb begin
    lineEnd  = (x == H_LAST);
    frameEnd = lineEnd && (y == V_LAST);
    active   = (x < H_ACT_END) && (y < V_ACT_END);
    hsNext   = !((x >= H_SYNC_START) && (x < H_SYNC_END));
    vsNext   = !((y >= V_SYNC_START) && (y < V_SYNC_END));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (pixTick) begin
      if (lineEnd) begin
        x <= '0;
        y <= frameEnd ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Output stage samples the pre-advance coordinate, giving one pixel of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r  <= '0;
      g  <= '0;
      b  <= '0;
      hs <= 1'b1;
      vs <= 1'b1;
    end else if (pixTick) begin
      r  <= active ? rIn : '0;
      g  <= active ? gIn : '0;
      b  <= active ? bIn : '0;
      hs <= hsNext;
      vs <= vsNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frameStart <= 1'b0;
    end else begin
      frameStart <= pixTick && frameEnd;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing on a shrunken raster (30x19, CLK_DIV=2) plus a
// CLK_DIV=1 instance; expected values are hand-derived from the reduced timing.
module tb_vga_timing;

  // Reduced raster: H 16/4/6/4 -> total 30, hs low x=20..25; V 12/2/2/3 -> total 19, vs low y=14..15
  logic        clk;
  logic        rst;
  logic [2:0]  rIn, gIn, bIn;
  logic [10:0] x, y, x1, y1;
  logic        pixTick, frameStart, pixTick1, frameStart1;
  logic [2:0]  r, g, b, r1, g1, b1;
  logic        hs, vs, hs1, vs1;

  int checks = 0;
  int errors = 0;

  vga_timing #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk(clk), .rst(rst), .rIn(rIn), .gIn(gIn), .bIn(bIn),
    .x(x), .y(y), .pixTick(pixTick), .frameStart(frameStart),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs)
  );

  vga_timing #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut1 (
    .clk(clk), .rst(rst), .rIn(rIn), .gIn(gIn), .bIn(bIn),
    .x(x1), .y(y1), .pixTick(pixTick1), .frameStart(frameStart1),
    .r(r1), .g(g1), .b(b1), .hs(hs1), .vs(vs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance on negedges until the tick for coordinate (xw, yw) is pending.
  task automatic waitXY(input int xw, input int yw, input string tag);
    int n = 0;
    while (!(pixTick && x == 11'(xw) && y == 11'(yw)) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkVal(tag, 32'(n < 5000), 1);
  endtask

  initial begin
    int lowClks;
    int periodClks;

    rst = 1'b1;
    rIn = 3'd7; gIn = 3'd7; bIn = 3'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_x", 32'(x), 0);
    checkVal("rst_y", 32'(y), 0);
    checkVal("rst_r", 32'(r), 0);
    checkVal("rst_g", 32'(g), 0);
    checkVal("rst_b", 32'(b), 0);
    checkVal("rst_hs", 32'(hs), 1);
    checkVal("rst_vs", 32'(vs), 1);
    checkVal("rst_frameStart", 32'(frameStart), 0);
    checkVal("rst_pixTick", 32'(pixTick), 0);
    checkVal("rst_pixTick_div1", 32'(pixTick1), 1);
    checkVal("rst_x_div1", 32'(x1), 0);

    rst = 1'b0;
    rIn = 3'd5; gIn = 3'd3; bIn = 3'd1;
    @(negedge clk);
    checkVal("first_tick", 32'(pixTick), 1);
    checkVal("first_tick_x", 32'(x), 0);

    // Active region and blanking boundary on line 10
    waitXY(10, 10, "wait_10_10");
    @(negedge clk);
    checkVal("act_r", 32'(r), 5);
    checkVal("act_g", 32'(g), 3);
    checkVal("act_b", 32'(b), 1);
    checkVal("act_x_adv", 32'(x), 11);
    checkVal("act_pixTick_div1", 32'(pixTick1), 1);
    waitXY(15, 10, "wait_15_10");
    @(negedge clk);
    checkVal("lastact_r", 32'(r), 5);
    waitXY(16, 10, "wait_16_10");
    @(negedge clk);
    checkVal("blank_r", 32'(r), 0);
    checkVal("blank_g", 32'(g), 0);
    checkVal("blank_b", 32'(b), 0);

    // Hsync width on line 11
    waitXY(19, 11, "wait_19_11");
    @(negedge clk);
    checkVal("hs_before", 32'(hs), 1);
    waitXY(20, 11, "wait_20_11");
    @(negedge clk);
    checkVal("hs_start", 32'(hs), 0);
    lowClks = 0;
    while (hs == 1'b0 && lowClks < 100) begin
      lowClks++;
      @(negedge clk);
    end
    checkVal("hs_low_clks", 32'(lowClks), 12);

    // Mid-frame line wrap
    waitXY(29, 12, "wait_29_12");
    @(negedge clk);
    checkVal("wrap_line_x", 32'(x), 0);
    checkVal("wrap_line_y", 32'(y), 13);
    checkVal("wrap_line_fs", 32'(frameStart), 0);

    // Vsync width
    waitXY(29, 13, "wait_29_13");
    @(negedge clk);
    checkVal("vs_before", 32'(vs), 1);
    waitXY(0, 14, "wait_0_14");
    @(negedge clk);
    checkVal("vs_start", 32'(vs), 0);
    lowClks = 0;
    while (vs == 1'b0 && lowClks < 1000) begin
      lowClks++;
      @(negedge clk);
    end
    checkVal("vs_low_clks", 32'(lowClks), 120);

    // Frame wrap and frameStart period
    waitXY(29, 18, "wait_29_18");
    @(negedge clk);
    checkVal("wrap_frame_x", 32'(x), 0);
    checkVal("wrap_frame_y", 32'(y), 0);
    checkVal("wrap_frame_fs", 32'(frameStart), 1);
    @(negedge clk);
    checkVal("fs_one_clk", 32'(frameStart), 0);
    periodClks = 1;
    while (!frameStart && periodClks < 5000) begin
      @(negedge clk);
      periodClks++;
    end
    checkVal("fs_period_clks", 32'(periodClks), 1140);
    checkVal("fs_period_x", 32'(x), 0);
    checkVal("fs_period_y", 32'(y), 0);

    // Reset while both syncs are low
    waitXY(22, 15, "wait_22_15");
    @(negedge clk);
    checkVal("mid_hs_low", 32'(hs), 0);
    checkVal("mid_vs_low", 32'(vs), 0);
    rst = 1'b1;
    @(negedge clk);
    checkVal("midrst_x", 32'(x), 0);
    checkVal("midrst_y", 32'(y), 0);
    checkVal("midrst_hs", 32'(hs), 1);
    checkVal("midrst_vs", 32'(vs), 1);
    checkVal("midrst_r", 32'(r), 0);
    checkVal("midrst_fs", 32'(frameStart), 0);
    checkVal("midrst_pixTick", 32'(pixTick), 0);
    checkVal("midrst_x_div1", 32'(x1), 0);
    rst = 1'b0;
    @(negedge clk);
    checkVal("resume_tick", 32'(pixTick), 1);
    @(negedge clk);
    checkVal("resume_x", 32'(x), 1);
    checkVal("resume_y", 32'(y), 0);
    checkVal("resume_hs", 32'(hs), 1);
    checkVal("resume_vs", 32'(vs), 1);
    checkVal("resume_r", 32'(r), 5);
    checkVal("resume_x_div1", 32'(x1), 2);
    checkVal("resume_pixTick_div1", 32'(pixTick1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Pixel-timing generator for the 640x480@60 Hz VGA display path. It derives a pixel-rate enable from the system clock and runs horizontal and vertical counters. It presents the current pixel coordinate to the combinational renderer on `x`/`y` and captures the renderer's colour reply one pixel later. It drives the registered, blank-masked colour plus hsync/vsync to the DAC pins, so colour and sync leave the block aligned.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (50 MHz -> 25 MHz pixel rate); must be >= 1
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync pulse width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync pulse width, lines
- `V_BP`, 33: vertical back porch, lines

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rIn`, `gIn`, `bIn`  in  3 each  renderer colour for the coordinate currently on `x`/`y`
- `x`  out  11  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800)
- `y`  out  11  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- `pixTick`  out  1  one-clk pulse; counters and outputs advance on this clk
- `frameStart`  out  1  one-clk pulse on the tick where counters wrap to (0,0)
- `r`, `g`, `b`  out  3 each  registered pixel colour to DAC
- `hs`, `vs`  out  1 each  registered sync, active-low

## Operation
- Divider `div` counts 0..CLK_DIV-1, then wraps. `pixTick` = (div == CLK_DIV-1), combinational from `div`.
- On `pixTick`, `x` advances. At H_TOTAL-1, `x` wraps to 0 and `y` advances. At V_TOTAL-1 with `x` = H_TOTAL-1, `y` wraps to 0.
- `x`/`y` come straight from the counter registers. The renderer computes colour combinationally within the same pixel period.
- Output register, updated only on `pixTick`, from the pre-advance counter values:
  - `active` = (x < H_ACTIVE) && (y < V_ACTIVE).
  - `r`/`g`/`b` take `rIn`/`gIn`/`bIn` when `active`, else 0. Blanking is enforced here regardless of renderer output.
  - `hs` = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - `vs` = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
- `frameStart` = `pixTick` && x == H_TOTAL-1 && y == V_TOTAL-1. This is registered so it asserts in the clk where `x`/`y` first read (0,0). It lasts exactly one clk.
- Widths: H_TOTAL and V_TOTAL computed as localparams. Counters are 11 bits, so totals must be <= 2047. Comparisons are unsigned.

## Timing
- Reset (rst high at an edge): div=0, x=0, y=0, r=g=b=0, hs=vs=1, frameStart=0. `pixTick` follows from div=0; it is 0 when CLK_DIV > 1.
- `rst` is honoured mid-line and mid-frame. All state returns to the reset values on the next edge, with no partial sync pulse emitted after that edge.
- First `pixTick` after reset release: CLK_DIV-1 clks later. With CLK_DIV=1, `pixTick` is constantly 1.
- Latency: colour/sync for coordinate (X,Y) appear on `r`/`g`/`b`/`hs`/`vs` one pixel period (CLK_DIV clks) after `x`/`y` present (X,Y). Outputs hold between ticks.
- `rIn`/`gIn`/`bIn` are sampled only on the `pixTick` clk. The renderer path must settle within one clk.
- Line = 800 ticks. Frame = 420000 ticks = 840000 clks at CLK_DIV=2.

## Test plan
- Reset: hold rst 3 clks with rIn=gIn=bIn=7 -> x=y=0, r=g=b=0, hs=vs=1, frameStart=0. First pixTick occurs 1 clk after release (CLK_DIV=2).
- Active pixel: rIn=5, gIn=3, bIn=1 constant, run to x=10, y=10 -> the tick after, r/g/b=5/3/1. At x=640 (same line), the following tick gives r=g=b=0.
- Hsync: on line y=0 -> hs goes low on the tick after x=656, stays low exactly 96 ticks (192 clks), then returns high.
- Vsync/frame: run a full frame -> vs low for exactly 2 lines (1600 ticks) starting after y=490, x=0. frameStart pulses once, one clk wide, 840000 clks apart, coinciding with x=y=0.
- Wrap: at x=799, y=524 with a tick -> next clk x=0, y=0, frameStart=1. At x=799, y=100 -> x=0, y=101, frameStart=0.
- Reset mid-operation: assert rst while x=700, y=491 (hs=0, vs=0) -> next edge all outputs at reset values. Counting resumes from (0,0) after release.
